control_unit: RTL and testbench



---
 rtl/control_unit.sv | 124 ++++++++++++
 tb/tb_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: instruction decode, Z/C flags and RUN/HALTED sequencing for the microc datapath.
// Optional build macro CONTROL_UNIT_ICOUNT_EN: when defined, a wrapping retired-instruction
// counter drives icount; when undefined, icount is tied to zero.
module control_unit #(
  parameter int unsigned ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              zero,
  input  logic              carry,
  output logic              s_skip,
  output logic              s_inc,
  output logic              s_inm,
  output logic              we,
  output logic [2:0]        ALUOp,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              illegal,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e state_q;
  logic   flag_z_q, flag_c_q, illegal_q;
  logic   dec_alu, dec_halt, dec_rsvd;
  logic   run_en;

  // State only advances in RUN outside of reset
  assign run_en = !reset && (state_q == StRun);

  // Opcode class, independent of state; feeds the sequential updates
  always_comb begin
    dec_alu  = 1'b0;
    dec_halt = 1'b0;
    dec_rsvd = 1'b0;
    casez (opcode)
      6'b0?????: dec_alu = 1'b1;
      6'b1000??, 6'b1001??,
      6'b101000, 6'b101001, 6'b101010,
      6'b101011, 6'b101100, 6'b101101: ;
      6'b111111: dec_halt = 1'b1;
      default:   dec_rsvd = 1'b1;
    endcase
  end

  // Datapath control: NOP values by default, forced during reset and while halted
  always_comb begin
    s_inc  = 1'b1;
    s_skip = 1'b0;
    s_inm  = 1'b0;
    we     = 1'b0;
    ALUOp  = 3'b000;
    if (reset) begin
      // keep NOP values
    end else if (state_q == StHalted) begin
      s_inc = 1'b0;
    end else begin
      unique casez (opcode)
        6'b0?????: begin
          we    = 1'b1;
          ALUOp = opcode[4:2];
        end
        6'b1000??: begin
          we    = 1'b1;
          s_inm = 1'b1;
        end
        6'b101000: s_inc  = 1'b0;
        6'b101001: s_inc  = ~flag_z_q;
        6'b101010: s_inc  = flag_z_q;
        6'b101011: s_inc  = ~flag_c_q;
        6'b101100: s_skip = flag_z_q;
        6'b101101: s_skip = flag_c_q;
        // Offset field of HALT is zero, so a relative jump holds the PC
        6'b111111: s_inc  = 1'b0;
        default: ;
      endcase
    end
  end

  // FSM, architectural flags and sticky illegal bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (dec_alu) begin
        flag_z_q <= zero;
        flag_c_q <= carry;
      end
      if (dec_rsvd) illegal_q <= 1'b1;
      if (dec_halt) state_q <= StHalted;
    end
  end

`ifdef CONTROL_UNIT_ICOUNT_EN
  logic [ICNT_W-1:0] icount_q;

  // Counts every RUN cycle including the HALT itself; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      icount_q <= '0;
    end else if (run_en) begin
      icount_q <= icount_q + 1'b1;
    end
  end

  assign icount = icount_q;
`else
  logic unused_run_en;
  assign unused_run_en = run_en;
  assign icount = '0;
`endif

  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == StHalted);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, icount wrap, random vs model.
module tb_control_unit;

  localparam int unsigned IcntW = 16;
`ifdef CONTROL_UNIT_ICOUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero, carry;
  logic             s_skip, s_inc, s_inm, we;
  logic [2:0]       ALUOp;
  logic             flag_z, flag_c, halted, illegal;
  logic [IcntW-1:0] icount;

  int total = 0;
  int bad   = 0;

  control_unit #(.ICNT_W(IcntW)) dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .carry  (carry),
    .s_skip (s_skip),
    .s_inc  (s_inc),
    .s_inm  (s_inm),
    .we     (we),
    .ALUOp  (ALUOp),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .halted (halted),
    .illegal(illegal),
    .icount (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z, c;
    logic       we, inc, skip, inm;
    logic [2:0] alu;
    logic       fz, fc, hlt, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic z, c,
                              input logic xwe, xinc, xskip, xinm, input logic [2:0] xalu,
                              input logic xfz, xfc, xhlt, xill);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.c = c;
    v.we = xwe; v.inc = xinc; v.skip = xskip; v.inm = xinm; v.alu = xalu;
    v.fz = xfz; v.fc = xfc; v.hlt = xhlt; v.ill = xill;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs settle before the rising edge
  task automatic apply(input logic r, input logic [5:0] op, input logic z, input logic c);
    @(negedge clk);
    reset = r; opcode = op; zero = z; carry = c;
    #2;
  endtask

  // Reference model state
  logic             m_halt, m_fz, m_fc, m_ill;
  logic [IcntW-1:0] m_cnt;

  task automatic model_comb(input logic r, input logic [5:0] op,
                            output logic xwe, xinc, xskip, xinm, output logic [2:0] xalu);
    int o;
    o = int'(op);
    xwe = 0; xinc = 1; xskip = 0; xinm = 0; xalu = 0;
    if (r) return;
    if (m_halt) begin
      xinc = 0;
      return;
    end
    if (o < 32) begin
      xwe = 1; xalu = 3'((o / 4) % 8);
    end else if (o < 36) begin
      xwe = 1; xinm = 1;
    end else if (o == 40) xinc = 0;
    else if (o == 41) xinc = !m_fz;
    else if (o == 42) xinc = m_fz;
    else if (o == 43) xinc = !m_fc;
    else if (o == 44) xskip = m_fz;
    else if (o == 45) xskip = m_fc;
    else if (o == 63) xinc = 0;
  endtask

  task automatic model_step(input logic r, input logic [5:0] op, input logic z, input logic c);
    int o;
    o = int'(op);
    if (r) begin
      m_halt = 0; m_fz = 0; m_fc = 0; m_ill = 0; m_cnt = 0;
    end else if (!m_halt) begin
      m_cnt = m_cnt + 1'b1;
      if (o < 32) begin
        m_fz = z; m_fc = c;
      end
      if (o >= 46 && o != 63) m_ill = 1;
      if (o == 63) m_halt = 1;
    end
  endtask

  initial begin
    logic             e_we, e_inc, e_skip, e_inm;
    logic [2:0]       e_alu;
    logic [IcntW-1:0] exp_cnt;
    logic             prev_hlt;
    logic             r, z, c;
    logic [5:0]       op;

    reset = 1'b1; opcode = '0; zero = 0; carry = 0;

    // ---------------- directed table ----------------
    vecs.push_back(mk(1, 6'b000000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6'b000000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000110, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 6'b101001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000110, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b101001, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b011100, 0, 1, 1, 1, 0, 0, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b100001, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b101101, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b101100, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b101011, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b101010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b100110, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 6'b110000, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 6'b000000, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 6'b101100, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 6'b101110, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b011111, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b101100, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b100001, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b110000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 6'b000000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000100, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6'b000100, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 6'b000011, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b000011, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));

    exp_cnt  = '0;
    prev_hlt = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].c);
      chk($sformatf("vec%0d.we", i),     int'(we),     int'(vecs[i].we));
      chk($sformatf("vec%0d.s_inc", i),  int'(s_inc),  int'(vecs[i].inc));
      chk($sformatf("vec%0d.s_skip", i), int'(s_skip), int'(vecs[i].skip));
      chk($sformatf("vec%0d.s_inm", i),  int'(s_inm),  int'(vecs[i].inm));
      chk($sformatf("vec%0d.ALUOp", i),  int'(ALUOp),  int'(vecs[i].alu));
      if (vecs[i].rst) exp_cnt = '0;
      else if (!prev_hlt) exp_cnt = exp_cnt + 1'b1;
      prev_hlt = vecs[i].hlt;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.flag_z", i),  int'(flag_z),  int'(vecs[i].fz));
      chk($sformatf("vec%0d.flag_c", i),  int'(flag_c),  int'(vecs[i].fc));
      chk($sformatf("vec%0d.halted", i),  int'(halted),  int'(vecs[i].hlt));
      chk($sformatf("vec%0d.illegal", i), int'(illegal), int'(vecs[i].ill));
      chk($sformatf("vec%0d.icount", i),  int'(icount),  CntEn ? int'(exp_cnt) : 0);
    end

    // ---------------- icount wrap ----------------
    apply(1, 6'b100100, 0, 0);
    apply(0, 6'b100100, 0, 0);
    if (CntEn) begin
      repeat (65535) @(posedge clk);
      #1 chk("icount_full", int'(icount), 65535);
      @(posedge clk); #1;
      chk("icount_wrap", int'(icount), 0);
    end else begin
      repeat (40) @(posedge clk);
      #1 chk("icount_tied", int'(icount), 0);
    end

    // ---------------- random vs model ----------------
    apply(1, 6'b000000, 0, 0);
    model_step(1, 6'b000000, 0, 0);
    @(posedge clk);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      op = 6'($urandom_range(0, 63));
      z  = 1'($urandom);
      c  = 1'($urandom);
      apply(r, op, z, c);
      model_comb(r, op, e_we, e_inc, e_skip, e_inm, e_alu);
      chk("rnd.we",     int'(we),     int'(e_we));
      chk("rnd.s_inc",  int'(s_inc),  int'(e_inc));
      chk("rnd.s_skip", int'(s_skip), int'(e_skip));
      chk("rnd.s_inm",  int'(s_inm),  int'(e_inm));
      chk("rnd.ALUOp",  int'(ALUOp),  int'(e_alu));
      model_step(r, op, z, c);
      @(posedge clk); #1;
      chk("rnd.flag_z",  int'(flag_z),  int'(m_fz));
      chk("rnd.flag_c",  int'(flag_c),  int'(m_fc));
      chk("rnd.halted",  int'(halted),  int'(m_halt));
      chk("rnd.illegal", int'(illegal), int'(m_ill));
      chk("rnd.icount",  int'(icount),  CntEn ? int'(m_cnt) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
